// File: rtl/fractal_pixel_sequencer_if.sv
// Mapper and frame-buffer buses of fractal_pixel_sequencer.
// PIX_W follows PIXEL_RGB565_EN: 16 when defined, 24 otherwise.
interface fractal_pixel_sequencer_if #(
   parameter int ADDR_W = 19,
`ifdef PIXEL_RGB565_EN
   parameter int PIX_W  = 16
`else
   parameter int PIX_W  = 24
`endif
);
   logic              map_draw;
   logic [9:0]        map_x;
   logic [9:0]        map_y;
   logic              map_done;
   logic [7:0]        map_r;
   logic [7:0]        map_g;
   logic [7:0]        map_b;
   logic              fb_req;
   logic [ADDR_W-1:0] fb_addr;
   logic [PIX_W-1:0]  fb_data;
   logic              fb_ack;

   modport master (
      output map_draw, map_x, map_y, fb_req, fb_addr, fb_data,
      input  map_done, map_r, map_g, map_b, fb_ack
   );

   modport slave (
      input  map_draw, map_x, map_y, fb_req, fb_addr, fb_data,
      output map_done, map_r, map_g, map_b, fb_ack
   );
endinterface

// File: rtl/fractal_pixel_sequencer.sv
// Raster-order pixel sequencer: mapper draw/done handshake, write FIFO, fb req/ack.
// PIXEL_RGB565_EN selects RGB565 packing at push time; default stores full RGB888.
module fractal_pixel_sequencer #(
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int FIFO_DEPTH   = 4,
   parameter int ADDR_W       = 19,
   parameter int DONE_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic frame_done,
   output logic timeout_err,
   fractal_pixel_sequencer_if.master bus
);
`ifdef PIXEL_RGB565_EN
   localparam int PIX_W = 16;
`else
   localparam int PIX_W = 24;
`endif
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = ADDR_W + PIX_W;
   localparam int TW    = $clog2(DONE_TIMEOUT + 1);
   localparam logic [9:0]    X_LAST = 10'(H_RES - 1);
   localparam logic [9:0]    Y_LAST = 10'(V_RES - 1);
   localparam logic [TW-1:0] T_MAX  = TW'(DONE_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_CAP, S_RELEASE, S_NEXT, S_DRAIN
   } state_t;

   state_t            state, state_next;
   logic [9:0]        x, y;
   logic [ADDR_W-1:0] addr;
   logic [TW-1:0]     tcnt;
   logic [PIX_W-1:0]  cap_pix, pix_in;
   logic [ENT_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr, rd_ptr;
   logic [ENT_W-1:0]  head;
   logic              empty, full, push, pop;

`ifdef PIXEL_RGB565_EN
   assign pix_in = {bus.map_r[7:3], bus.map_g[7:2], bus.map_b[7:3]};
`else
   assign pix_in = {bus.map_r, bus.map_g, bus.map_b};
`endif

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop   = !empty && bus.fb_ack;
   assign head  = mem[rd_ptr[PTR_W-1:0]];

   assign bus.fb_req  = !empty;
   assign bus.fb_addr = head[ENT_W-1 -: ADDR_W];
   assign bus.fb_data = head[PIX_W-1:0];
   assign bus.map_x   = x;
   assign bus.map_y   = y;
   assign busy        = (state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next   = state;
      bus.map_draw = 1'b0;
      push         = 1'b0;
      frame_done   = 1'b0;
      case (state)
         S_IDLE:    if (start) state_next = S_ISSUE;
         S_ISSUE: begin
            bus.map_draw = 1'b1;
            state_next   = S_WAIT;
         end
         S_WAIT: begin
            bus.map_draw = 1'b1;
            if (bus.map_done || tcnt == T_MAX) state_next = S_CAP;
         end
         // A full FIFO may still accept the push when its head pops this cycle.
         S_CAP: begin
            bus.map_draw = 1'b1;
            if (!full || pop) begin
               push       = 1'b1;
               state_next = S_RELEASE;
            end
         end
         S_RELEASE: if (!bus.map_done) state_next = S_NEXT;
         S_NEXT:    state_next = (x == X_LAST && y == Y_LAST) ? S_DRAIN : S_ISSUE;
         S_DRAIN: begin
            if (empty) begin
               frame_done = 1'b1;
               state_next = S_IDLE;
            end
         end
         default:   state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x           <= '0;
         y           <= '0;
         addr        <= '0;
         tcnt        <= '0;
         cap_pix     <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  x           <= '0;
                  y           <= '0;
                  addr        <= '0;
                  timeout_err <= 1'b0;
               end
            end
            S_ISSUE: tcnt <= '0;
            S_WAIT: begin
               tcnt <= tcnt + 1'b1;
               if (bus.map_done) begin
                  cap_pix <= pix_in;
               end else if (tcnt == T_MAX) begin
                  cap_pix     <= '0;
                  timeout_err <= 1'b1;
               end
            end
            // Raster walk doubles as the incremental y*H_RES+x address.
            S_NEXT: begin
               if (x == X_LAST && y == Y_LAST) begin
                  x    <= '0;
                  y    <= '0;
                  addr <= '0;
               end else begin
                  addr <= addr + 1'b1;
                  if (x == X_LAST) begin
                     x <= '0;
                     y <= y + 1'b1;
                  end else begin
                     x <= x + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < unsigned'(FIFO_DEPTH); i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= {addr, cap_pix};
            wr_ptr                 <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

// File: tb/tb_fractal_pixel_sequencer.sv
// Directed bench for fractal_pixel_sequencer on a 4x2 frame with a latency-40 mapper model.
// Honours PIXEL_RGB565_EN for the mapper colours and expected packed data.
module tb_fractal_pixel_sequencer;
   localparam int ADDR_W = 3;
`ifdef PIXEL_RGB565_EN
   localparam int PIX_W = 16;
`else
   localparam int PIX_W = 24;
`endif

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [2:0]  addr;
      logic [23:0] data;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic busy, frame_done, timeout_err;
   logic hang_en = 1'b0;
   logic [5:0] lat;

   int n_tests = 0;
   int n_fail  = 0;
   int nfd     = 0;
   int nd_rise = 0;
   logic prev_draw = 1'b0;
   logic prev_done = 1'b0;
   logic [2:0]       wa_q[$];
   logic [PIX_W-1:0] wd_q[$];
   logic [19:0]      xy_q[$];
   vec_t tbl[8];

   fractal_pixel_sequencer_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

   fractal_pixel_sequencer #(
      .H_RES(4), .V_RES(2), .FIFO_DEPTH(4), .ADDR_W(ADDR_W), .DONE_TIMEOUT(255)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy),
      .frame_done(frame_done), .timeout_err(timeout_err), .bus(bus)
   );

   always #5 clk = ~clk;

   // Mapper model: done 40 cycles after draw rises, held until draw falls.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.map_done <= 1'b0;
         lat          <= '0;
      end else if (!bus.map_draw) begin
         bus.map_done <= 1'b0;
         lat          <= '0;
      end else if (!bus.map_done) begin
         if (lat >= 6'd39) begin
            if (!(hang_en && bus.map_x == 10'd2 && bus.map_y == 10'd1)) begin
               bus.map_done <= 1'b1;
`ifdef PIXEL_RGB565_EN
               bus.map_r <= 8'hFF;
               bus.map_g <= 8'h80;
               bus.map_b <= 8'h1F;
`else
               bus.map_r <= {bus.map_x[3:0], 4'h0};
               bus.map_g <= {bus.map_y[2:0], 5'h00};
               bus.map_b <= 8'h5A;
`endif
            end
         end else begin
            lat <= lat + 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.fb_req && bus.fb_ack) begin
            wa_q.push_back(bus.fb_addr);
            wd_q.push_back(bus.fb_data);
         end
         if (frame_done) nfd++;
         if (bus.map_draw && !prev_draw) xy_q.push_back({bus.map_x, bus.map_y});
         if (bus.map_done && !prev_done) nd_rise++;
      end
      prev_draw = bus.map_draw;
      prev_done = bus.map_done;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      wa_q.delete();
      wd_q.delete();
      xy_q.delete();
      nfd     = 0;
      nd_rise = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".busy"},        busy,         0);
      chk({tag, ".frame_done"},  frame_done,   0);
      chk({tag, ".timeout_err"}, timeout_err,  0);
      chk({tag, ".map_draw"},    bus.map_draw, 0);
      chk({tag, ".map_xy"},      {bus.map_x, bus.map_y}, 0);
      chk({tag, ".fb_req"},      bus.fb_req,   0);
      chk({tag, ".fb_addr"},     bus.fb_addr,  0);
      chk({tag, ".fb_data"},     bus.fb_data,  0);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 4000) begin
         tick(1);
         n++;
      end
      chk({tag, ".idle_in_time"}, busy, 0);
      tick(3);
   endtask

   task automatic check_frame(input string tag, input bit hang6);
      logic [31:0] exp_d;
      chk({tag, ".n_writes"},    wa_q.size(), 8);
      chk({tag, ".n_draws"},     xy_q.size(), 8);
      chk({tag, ".frame_done"},  nfd, 1);
      for (int i = 0; i < 8; i++) begin
`ifdef PIXEL_RGB565_EN
         exp_d = 32'h0000FC03;
`else
         exp_d = {8'h00, tbl[i].data};
`endif
         if (hang6 && i == 6) exp_d = '0;
         if (i < wa_q.size()) begin
            chk($sformatf("%s.addr[%0d]", tag, i), wa_q[i], tbl[i].addr);
            chk($sformatf("%s.data[%0d]", tag, i), wd_q[i], exp_d);
         end
         if (i < xy_q.size())
            chk($sformatf("%s.xy[%0d]", tag, i), xy_q[i], {tbl[i].x, tbl[i].y});
      end
   endtask

   initial begin
      int n;
      tbl[0] = '{10'd0, 10'd0, 3'd0, 24'h00005A};
      tbl[1] = '{10'd1, 10'd0, 3'd1, 24'h10005A};
      tbl[2] = '{10'd2, 10'd0, 3'd2, 24'h20005A};
      tbl[3] = '{10'd3, 10'd0, 3'd3, 24'h30005A};
      tbl[4] = '{10'd0, 10'd1, 3'd4, 24'h00205A};
      tbl[5] = '{10'd1, 10'd1, 3'd5, 24'h10205A};
      tbl[6] = '{10'd2, 10'd1, 3'd6, 24'h20205A};
      tbl[7] = '{10'd3, 10'd1, 3'd7, 24'h30205A};
      bus.fb_ack = 1'b1;
      bus.map_r  = '0;
      bus.map_g  = '0;
      bus.map_b  = '0;

      tick(3);
      check_zero("rst");
      reset = 1'b0;
      tick(2);
      check_zero("post_rst");

      // 1: plain frame, ack always high
      clear_obs();
      pulse_start();
      chk("t1.busy_after_start", busy, 1);
      wait_idle("t1");
      check_frame("t1", 1'b0);
      chk("t1.timeout_err", timeout_err, 0);

      // 2: backpressure until the FIFO fills and the 5th pixel stalls in CAP
      clear_obs();
      bus.fb_ack = 1'b0;
      pulse_start();
      n = 0;
      while (nd_rise < 5 && n < 2000) begin
         tick(1);
         n++;
      end
      chk("t2.fifth_done_seen", nd_rise >= 5, 1);
      tick(40);
      chk("t2.stall_draw",  bus.map_draw, 1);
      chk("t2.stall_xy",    {bus.map_x, bus.map_y}, {10'd0, 10'd1});
      chk("t2.stall_req",   bus.fb_req, 1);
      chk("t2.head_addr",   bus.fb_addr, 0);
      chk("t2.n_writes_stalled", wa_q.size(), 0);
      tick(20);
      chk("t2.still_stalled", {bus.map_draw, bus.map_x, bus.map_y}, {1'b1, 10'd0, 10'd1});
      bus.fb_ack = 1'b1;
      wait_idle("t2");
      check_frame("t2", 1'b0);

      // 3: mapper never answers pixel (2,1)
      clear_obs();
      hang_en = 1'b1;
      pulse_start();
      wait_idle("t3");
      hang_en = 1'b0;
      check_frame("t3", 1'b1);
      chk("t3.timeout_err_set", timeout_err, 1);
      tick(5);
      chk("t3.timeout_err_sticky", timeout_err, 1);
      clear_obs();
      pulse_start();
      chk("t3.timeout_err_cleared", timeout_err, 0);
      wait_idle("t3b");
      check_frame("t3b", 1'b0);

      // 4: reset during the 3rd pixel's WAIT
      clear_obs();
      pulse_start();
      n = 0;
      while (!(bus.map_draw && bus.map_x == 10'd2) && n < 1000) begin
         tick(1);
         n++;
      end
      chk("t4.third_pixel_reached", {bus.map_draw, bus.map_x}, {1'b1, 10'd2});
      tick(3);
      reset = 1'b1;
      #1;
      check_zero("t4.rst");
      tick(2);
      reset = 1'b0;
      tick(60);
      chk("t4.no_frame_done", nfd, 0);
      chk("t4.idle", busy, 0);
      clear_obs();
      pulse_start();
      wait_idle("t4b");
      check_frame("t4b", 1'b0);

      // 5: start pulsed mid-frame is ignored
      clear_obs();
      pulse_start();
      tick(100);
      pulse_start();
      tick(50);
      pulse_start();
      wait_idle("t5");
      check_frame("t5", 1'b0);
      chk("t5.busy_end", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
